// File: rtl/async_fifo.sv
// Byte-wide FIFO on a single clock that keeps the two-domain pointer structure:
// Gray-coded write/read pointers cross to the opposite side through SYNC_STAGES
// flops, so full and empty are conservative but can never overflow or underflow.
// ADDR_WIDTH must be at least 2 for the full comparison below.
module async_fifo #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_inc,
    input  logic [DATA_WIDTH-1:0] W_data,
    input  logic                  R_inc,
    output logic [DATA_WIDTH-1:0] R_data,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d;
    logic [PW-1:0] rbin_q, rbin_d, rgray_q, rgray_d;
    // wsync_q carries the write Gray pointer to the read side, rsync_q the reverse
    logic [PW-1:0] wsync_q [SYNC_STAGES];
    logic [PW-1:0] rsync_q [SYNC_STAGES];
    logic [PW-1:0] rsync_last, wsync_last;

    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  w_en, r_en;

    assign wsync_last = wsync_q[SYNC_STAGES-1];
    assign rsync_last = rsync_q[SYNC_STAGES-1];

    // Flags come straight from registers; full compares against the read
    // pointer with its wrap and MSB-1 bits inverted (Gray equivalent of +DEPTH).
    assign empty  = (rgray_q == wsync_last);
    assign full   = (wgray_q == {~rsync_last[PW-1:PW-2], rsync_last[PW-3:0]});
    assign R_data = rdata_q;

    // Next-state for pointers and read data; each side gated only by its own flag
    always_comb begin
        w_en    = W_inc & ~full;
        r_en    = R_inc & ~empty;
        wbin_d  = wbin_q + {{ADDR_WIDTH{1'b0}}, w_en};
        rbin_d  = rbin_q + {{ADDR_WIDTH{1'b0}}, r_en};
        wgray_d = wbin_d ^ (wbin_d >> 1);
        rgray_d = rbin_d ^ (rbin_d >> 1);
        rdata_d = rdata_q;
        if (r_en) begin
            rdata_d = mem_q[rbin_q[ADDR_WIDTH-1:0]];
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge CLK) begin
        if (w_en) begin
            mem_q[wbin_q[ADDR_WIDTH-1:0]] <= W_data;
        end
    end

    // Pointer, read-data and synchronizer state
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            rbin_q  <= '0;
            rgray_q <= '0;
            rdata_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                wsync_q[i] <= '0;
                rsync_q[i] <= '0;
            end
        end else begin
            wbin_q     <= wbin_d;
            wgray_q    <= wgray_d;
            rbin_q     <= rbin_d;
            rgray_q    <= rgray_d;
            rdata_q    <= rdata_d;
            wsync_q[0] <= wgray_q;
            rsync_q[0] <= rgray_q;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                wsync_q[i] <= wsync_q[i-1];
                rsync_q[i] <= rsync_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo: stimulus pushes the expected popped word,
// a monitor pops and compares after every accepted read.
module tb_async_fifo;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       W_inc = 1'b0;
    logic [7:0] W_data = 8'h00;
    logic       R_inc = 1'b0;
    logic [7:0] R_data;
    logic       full;
    logic       empty;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q [$];

    async_fifo #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (3),
        .SYNC_STAGES(2)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .W_inc (W_inc),
        .W_data(W_data),
        .R_inc (R_inc),
        .R_data(R_data),
        .full  (full),
        .empty (empty)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Monitor: an accepted pop must present the next scoreboard word
    logic mon_fire;
    logic [7:0] mon_exp;
    always @(posedge CLK) begin
        mon_fire = RST && R_inc && !empty;
        #1;
        if (mon_fire) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pop: got %0h, expected no pop", R_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rdata", {24'd0, R_data}, {24'd0, mon_exp});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int wv, rv, wc, rc;

    initial begin
        // Reset
        idle(2);
        check("reset_empty", {31'd0, empty}, 32'd1);
        check("reset_full", {31'd0, full}, 32'd0);
        check("reset_rdata", {24'd0, R_data}, 32'd0);
        RST = 1'b1;
        idle(1);

        // Single word: empty clears exactly two edges after the write
        W_inc = 1'b1; W_data = 8'h01;
        @(negedge CLK);
        W_inc = 1'b0;
        check("empty_lat0", {31'd0, empty}, 32'd1);
        @(negedge CLK);
        check("empty_lat1", {31'd0, empty}, 32'd1);
        @(negedge CLK);
        check("empty_lat2", {31'd0, empty}, 32'd0);
        R_inc = 1'b1; exp_q.push_back(8'h01);
        @(negedge CLK);
        R_inc = 1'b0;
        check("single_empty", {31'd0, empty}, 32'd1);
        idle(3);

        // Fill, overflow attempt, drain
        for (int v = 1; v <= 8; v++) begin
            W_inc = 1'b1; W_data = 8'(v);
            @(negedge CLK);
            if (v == 7) check("full_at7", {31'd0, full}, 32'd0);
        end
        check("full_at8", {31'd0, full}, 32'd1);
        W_data = 8'h09;
        @(negedge CLK);
        W_inc = 1'b0;
        check("full_hold", {31'd0, full}, 32'd1);
        idle(2);
        for (int v = 1; v <= 8; v++) begin
            R_inc = 1'b1; exp_q.push_back(8'(v));
            @(negedge CLK);
        end
        R_inc = 1'b0;
        check("drain_empty", {31'd0, empty}, 32'd1);
        idle(3);
        check("drain_full", {31'd0, full}, 32'd0);

        // Wrap-around: writer every 3 cycles, reader every 5 cycles
        wv = 1; rv = 1; wc = 0; rc = 0;
        fork
            begin
                while (wv <= 14 && wc < 600) begin
                    if (!full) begin
                        W_inc = 1'b1; W_data = 8'(wv); wv++;
                        @(negedge CLK);
                        W_inc = 1'b0;
                        idle(2);
                        wc += 3;
                    end else begin
                        @(negedge CLK);
                        wc++;
                    end
                end
            end
            begin
                while (rv <= 14 && rc < 600) begin
                    if (!empty) begin
                        R_inc = 1'b1; exp_q.push_back(8'(rv)); rv++;
                        @(negedge CLK);
                        R_inc = 1'b0;
                        idle(4);
                        rc += 5;
                    end else begin
                        @(negedge CLK);
                        rc++;
                    end
                end
            end
        join
        check("wrap_writes", wv, 32'd15);
        check("wrap_reads", rv, 32'd15);
        idle(2);
        check("wrap_empty", {31'd0, empty}, 32'd1);

        // Underflow: pop on empty is ignored
        R_inc = 1'b1;
        @(negedge CLK);
        R_inc = 1'b0;
        check("uflow_rdata", {24'd0, R_data}, 32'd14);
        check("uflow_empty", {31'd0, empty}, 32'd1);
        check("uflow_full", {31'd0, full}, 32'd0);

        // Simultaneous push and pop with four words stored
        for (int v = 21; v <= 24; v++) begin
            W_inc = 1'b1; W_data = 8'(v);
            @(negedge CLK);
        end
        W_inc = 1'b0;
        idle(3);
        for (int i = 0; i < 4; i++) begin
            W_inc = 1'b1; W_data = 8'(25 + i);
            R_inc = 1'b1; exp_q.push_back(8'(21 + i));
            @(negedge CLK);
        end
        W_inc = 1'b0; R_inc = 1'b0;
        check("simul_empty", {31'd0, empty}, 32'd0);
        check("simul_full", {31'd0, full}, 32'd0);
        idle(3);
        for (int v = 25; v <= 28; v++) begin
            R_inc = 1'b1; exp_q.push_back(8'(v));
            @(negedge CLK);
        end
        R_inc = 1'b0;
        check("simul_drain_empty", {31'd0, empty}, 32'd1);
        idle(1);

        // Reset mid-stream with five words stored
        for (int v = 31; v <= 35; v++) begin
            W_inc = 1'b1; W_data = 8'(v);
            @(negedge CLK);
        end
        W_inc = 1'b0;
        idle(3);
        check("pre_rst_empty", {31'd0, empty}, 32'd0);
        RST = 1'b0;
        #1;
        check("midrst_empty", {31'd0, empty}, 32'd1);
        check("midrst_full", {31'd0, full}, 32'd0);
        check("midrst_rdata", {24'd0, R_data}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        idle(1);
        W_inc = 1'b1; W_data = 8'hAA;
        @(negedge CLK);
        W_inc = 1'b0;
        idle(3);
        R_inc = 1'b1; exp_q.push_back(8'hAA);
        @(negedge CLK);
        R_inc = 1'b0;
        check("post_rst_rdata", {24'd0, R_data}, 32'h0AA);
        check("post_rst_empty", {31'd0, empty}, 32'd1);
        idle(2);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
